// File: rtl/fll_bus_responder_pkg.sv
// Shared types, register addresses and field helpers for the FLL bus responder.
package fll_bus_responder_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 2;
  localparam int unsigned MULT_W     = 16;
  localparam int unsigned LOCK_CYC_W = 16;
  localparam int unsigned LAT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_ACK,
    ST_WAIT
  } fsm_state_e;

  localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_CFG1   = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_CFG2   = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_INTEG  = 2'd3;

  function automatic logic [MULT_W-1:0] mult_field(input logic [DATA_W-1:0] r);
    return r[MULT_W-1:0];
  endfunction

  function automatic logic [LOCK_CYC_W-1:0] lock_cyc_field(input logic [DATA_W-1:0] r);
    return r[LOCK_CYC_W-1:0];
  endfunction

endpackage

// File: rtl/FLL_BUS.sv
// FLL control bus: requester drives req/wrn/addr/wdata, responder returns ack/rdata/lock.
interface FLL_BUS;
  logic        req;
  logic        wrn;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        lock;

  modport in  (input req, wrn, addr, wdata, output ack, rdata, lock);
  modport out (output req, wrn, addr, wdata, input ack, rdata, lock);
endinterface

// File: rtl/fll_emu_core.sv
// Emulated FLL: multiplier ramps toward the target, lock after a settle period.
module fll_emu_core
  import fll_bus_responder_pkg::*;
#(
  parameter int unsigned RAMP_DIV = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [MULT_W-1:0]     target,
  input  logic [LOCK_CYC_W-1:0] lock_cycles,
  input  logic                  clr,
  output logic [MULT_W-1:0]     mult,
  output logic                  lock
);

  localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [DIV_W-1:0]      div_cnt;
  logic [LOCK_CYC_W-1:0] settle;
  logic                  tick_c;
  logic [LOCK_CYC_W-1:0] settle_inc_c;

  assign tick_c       = (div_cnt == DIV_W'(RAMP_DIV - 1));
  assign settle_inc_c = (settle == '1) ? settle : settle + 1'b1;

  // A target change (clr) suppresses the ramp step on that edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt <= '0;
      mult    <= '0;
      settle  <= '0;
      lock    <= 1'b0;
    end else begin
      div_cnt <= tick_c ? '0 : div_cnt + 1'b1;
      if (tick_c && !clr) begin
        if (mult < target)      mult <= mult + 1'b1;
        else if (mult > target) mult <= mult - 1'b1;
      end
      if (clr || (mult != target)) begin
        settle <= '0;
        lock   <= 1'b0;
      end else begin
        settle <= settle_inc_c;
        lock   <= (settle_inc_c >= lock_cycles);
      end
    end
  end

endmodule

// File: rtl/fll_bus_responder.sv
// FLL bus responder: bus FSM and register bank in front of the emulated FLL core.
module fll_bus_responder
  import fll_bus_responder_pkg::*;
#(
  parameter int unsigned       ACK_LATENCY = 1,
  parameter int unsigned       RAMP_DIV    = 4,
  parameter logic [DATA_W-1:0] CFG1_RST    = 32'h0000_05F5,
  parameter logic [DATA_W-1:0] CFG2_RST    = 32'h0000_0010
) (
  input  logic              clk_i,
  input  logic              rst_i,
  FLL_BUS.in                fll,
  output logic [MULT_W-1:0] mult_o
);

  fsm_state_e        state;
  logic [LAT_W-1:0]  lat_cnt;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cfg1;
  logic [DATA_W-1:0] cfg2;
  logic [DATA_W-1:0] integ;
  logic              ack_q;
  logic [DATA_W-1:0] rdata_q;
  logic              lock;
  logic [MULT_W-1:0] mult;
  logic              commit_c;
  logic              clr_c;
  logic [DATA_W-1:0] rd_val_c;

  assign commit_c = (state == ST_BUSY) && (lat_cnt == '0);
  assign clr_c    = commit_c && wr_q && (addr_q == ADDR_CFG1)
                    && (mult_field(wdata_q) != mult_field(cfg1));

  // Read value as seen after this transaction's own write commits.
  always_comb begin
    rd_val_c = '0;
    case (addr_q)
      ADDR_STATUS: rd_val_c = {lock, 15'b0, mult};
      ADDR_CFG1:   rd_val_c = wr_q ? wdata_q : cfg1;
      ADDR_CFG2:   rd_val_c = wr_q ? wdata_q : cfg2;
      ADDR_INTEG:  rd_val_c = wr_q ? wdata_q : integ;
      default:     rd_val_c = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      lat_cnt <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cfg1    <= CFG1_RST;
      cfg2    <= CFG2_RST;
      integ   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      case (state)
        ST_IDLE: begin
          if (fll.req) begin
            wr_q    <= fll.wrn;
            addr_q  <= fll.addr;
            wdata_q <= fll.wdata;
            lat_cnt <= LAT_W'(ACK_LATENCY - 1);
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (lat_cnt == '0) begin
            state   <= ST_ACK;
            ack_q   <= 1'b1;
            rdata_q <= rd_val_c;
            if (wr_q) begin
              case (addr_q)
                ADDR_CFG1:  cfg1  <= wdata_q;
                ADDR_CFG2:  cfg2  <= wdata_q;
                ADDR_INTEG: integ <= wdata_q;
                default:    ;
              endcase
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_ACK:  state <= ST_WAIT;
        ST_WAIT: if (!fll.req) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  fll_emu_core #(
    .RAMP_DIV (RAMP_DIV)
  ) u_core (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .target      (mult_field(cfg1)),
    .lock_cycles (lock_cyc_field(cfg2)),
    .clr         (clr_c),
    .mult        (mult),
    .lock        (lock)
  );

  assign fll.ack   = ack_q;
  assign fll.rdata = rdata_q;
  assign fll.lock  = lock;
  assign mult_o    = mult;

endmodule

// File: tb/tb_fll_bus_responder.sv
// Directed bench for fll_bus_responder: bus timing, register map, ramp and lock behaviour.
module tb_fll_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mult;
  logic [15:0] mult3;
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc;

  FLL_BUS bus ();
  FLL_BUS bus3 ();

  always #5 clk = ~clk;

  fll_bus_responder dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .fll    (bus),
    .mult_o (mult)
  );

  fll_bus_responder #(.ACK_LATENCY(3)) dut3 (
    .clk_i  (clk),
    .rst_i  (rst),
    .fll    (bus3),
    .mult_o (mult3)
  );

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction on the main bus; call and return at a negedge with the DUT idle.
  task automatic bus_xfer(input logic wr, input logic [1:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int lat, output logic lk);
    bus.req = 1'b1; bus.wrn = wr; bus.addr = a; bus.wdata = d;
    rd = '0; lat = -1; lk = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus.ack) begin
        lat = i; rd = bus.rdata; lk = bus.lock;
        break;
      end
    end
    bus.req = 1'b0;
    if (lat < 0) chk("ack_timeout", 32'd0, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("ack_width", 32'(bus.ack), 32'd0);
    @(posedge clk); @(negedge clk);
  endtask

  logic [31:0] rd;
  int          lat;
  logic        lk;
  int          n;
  int          acks;
  int          first;
  logic [15:0] m0;

  initial begin
    rst = 1'b1;
    bus.req = 0;  bus.wrn = 0;  bus.addr = 0;  bus.wdata = 0;
    bus3.req = 0; bus3.wrn = 0; bus3.addr = 0; bus3.wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ack",   32'(bus.ack), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_lock",  32'(bus.lock), 32'd0);
    chk("rst_mult",  32'(mult), 32'd0);

    bus_xfer(1'b0, 2'd1, 32'd0, rd, lat, lk);
    chk("rd_cfg1", rd, 32'h0000_05F5);
    chk("rd_cfg1_lat", 32'(lat), 32'd1);
    chk("rd_cfg1_lock", 32'(lk), 32'd0);
    bus_xfer(1'b0, 2'd2, 32'd0, rd, lat, lk);
    chk("rd_cfg2", rd, 32'h0000_0010);
    bus_xfer(1'b0, 2'd3, 32'd0, rd, lat, lk);
    chk("rd_integ", rd, 32'h0000_0000);

    // Ramp up from reset: step n lands on edge 4n, lock 16 edges after target.
    while (cyc != 400) @(negedge clk);
    chk("ramp_400", 32'(mult), 32'd100);
    n = 0;
    while (mult != 16'h05F5 && n < 8000) begin @(negedge clk); n++; end
    chk("ramp_done_cyc", cyc, 32'd6100);
    n = 0;
    while (!bus.lock && n < 100) begin @(negedge clk); n++; end
    chk("lock_up", 32'(bus.lock), 32'd1);
    chk("lock_cyc", cyc, 32'd6116);
    bus_xfer(1'b0, 2'd0, 32'd0, rd, lat, lk);
    chk("rd_status_locked", rd, 32'h8000_05F5);

    // Retarget while locked.
    bus_xfer(1'b1, 2'd1, 32'h0000_0100, rd, lat, lk);
    chk("wr_cfg1_rdata", rd, 32'h0000_0100);
    chk("wr_cfg1_lock_clr", 32'(lk), 32'd0);
    m0 = mult;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("ramp_down_40", 32'(mult), 32'(m0 - 16'd10));
    chk("unlocked_ramp", 32'(bus.lock), 32'd0);
    n = 0;
    while (!bus.lock && n < 6000) begin @(negedge clk); n++; end
    chk("relock", 32'(bus.lock), 32'd1);
    chk("relock_mult", 32'(mult), 32'h0100);

    bus_xfer(1'b1, 2'd1, 32'h0000_0100, rd, lat, lk);
    chk("same_cfg1_lock", 32'(lk), 32'd1);
    chk("same_cfg1_lock_after", 32'(bus.lock), 32'd1);

    bus_xfer(1'b1, 2'd3, 32'hDEAD_BEEF, rd, lat, lk);
    chk("wr_integ_rdata", rd, 32'hDEAD_BEEF);
    bus_xfer(1'b1, 2'd0, 32'hFFFF_FFFF, rd, lat, lk);
    chk("wr_status_rdata", rd, 32'h8000_0100);
    bus_xfer(1'b0, 2'd3, 32'd0, rd, lat, lk);
    chk("rd_integ_kept", rd, 32'hDEAD_BEEF);
    bus_xfer(1'b0, 2'd0, 32'd0, rd, lat, lk);
    chk("rd_status_kept", rd, 32'h8000_0100);

    // Latency-3 build with req held for 10 cycles.
    bus3.req = 1'b1; bus3.wrn = 1'b0; bus3.addr = 2'd3;
    acks = 0; first = -1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus3.ack) begin
        acks++;
        if (first < 0) first = i;
      end
    end
    bus3.req = 1'b0;
    chk("lat3_first", 32'(first), 32'd3);
    chk("lat3_count", 32'(acks), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus3.req = 1'b1; bus3.addr = 2'd1;
    first = -1; rd = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus3.ack && first < 0) begin first = i; rd = bus3.rdata; end
    end
    bus3.req = 1'b0;
    chk("lat3_second", 32'(first), 32'd3);
    chk("lat3_rd_cfg1", rd, 32'h0000_05F5);

    // Reset during BUSY of a CFG2 write.
    bus.req = 1'b1; bus.wrn = 1'b1; bus.addr = 2'd2; bus.wdata = 32'h0000_1234;
    @(posedge clk); @(negedge clk);
    rst = 1'b1; bus.req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_mid_ack", 32'(bus.ack), 32'd0);
    chk("rst_mid_mult", 32'(mult), 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    bus_xfer(1'b0, 2'd2, 32'd0, rd, lat, lk);
    chk("rst_mid_cfg2", rd, 32'h0000_0010);
    bus_xfer(1'b0, 2'd1, 32'd0, rd, lat, lk);
    chk("rst_mid_cfg1", rd, 32'h0000_05F5);
    bus_xfer(1'b0, 2'd3, 32'd0, rd, lat, lk);
    chk("rst_mid_integ", rd, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
